// File: rtl/id_exe_skid_reg.sv
// ID->EXE pipeline register with a one-entry skid buffer so that in_ready is fully registered.
// Optional back-pressure counter on stall_cnt when ID_EXE_STALL_CNT_EN is defined.
module id_exe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [8:0]                 in_ctrl,
    input  logic [4*DATA_W+DEST_W-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [8:0]                 out_ctrl,
    output logic [4*DATA_W+DEST_W-1:0] out_data
`ifdef ID_EXE_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int PW = 4*DATA_W + DEST_W;

    logic          main_valid;
    logic [8:0]    main_ctrl;
    logic [PW-1:0] main_data;
    logic          skid_valid;
    logic [8:0]    skid_ctrl;
    logic [PW-1:0] skid_data;

    logic accept;
    logic main_free;

    // skid_valid is itself a flop, so in_ready never depends on out_ready.
    assign in_ready  = ~skid_valid;
    assign accept    = in_valid & in_ready;
    assign main_free = ~main_valid | out_ready;

    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // With skid full in_ready is low, so skid and input never compete for main.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_ctrl  <= in_ctrl;
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
        end
    end

`ifdef ID_EXE_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_exe_skid_reg.sv
// Self-checking bench for id_exe_skid_reg: directed scenarios plus random traffic against a queue model.
module tb_id_exe_skid_reg;

    localparam int DW  = 32;
    localparam int DSW = 5;
    localparam int PW  = 4*DW + DSW;

    typedef struct packed {
        logic [8:0]    ctrl;
        logic [PW-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [8:0]    in_ctrl;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [8:0]    out_ctrl;
    logic [PW-1:0] out_data;
`ifdef ID_EXE_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    item_t       q[$];
    int unsigned stall_m;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    id_exe_skid_reg #(.DATA_W(DW), .DEST_W(DSW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
`ifdef ID_EXE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [31:0] pc);
        logic [4:0] d;
        d = 5'($urandom);
        return {pc, $urandom, $urandom, $urandom, d};
    endfunction

    function automatic logic [31:0] pc_of(input logic [PW-1:0] d);
        return d[PW-1 -: DW];
    endfunction

    task automatic check_all();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("out_ctrl", out_ctrl, q[0].ctrl);
            chk("out_data", out_data, q[0].data);
        end else begin
            chk("bubble_ctrl", out_ctrl, 9'h000);
        end
`ifdef ID_EXE_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stall_m);
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check at the following negedge.
    task automatic step(input logic v, input logic [8:0] c, input logic [PW-1:0] d,
                        input logic ordy, input logic fl);
        bit m_in_ready;
        bit m_out_valid;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        m_in_ready  = q.size() < 2;
        m_out_valid = q.size() > 0;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            stall_m = 0;
        end else begin
            if (m_out_valid && !ordy && stall_m < 65535) stall_m++;
            if (fl) begin
                q.delete();
            end else begin
                if (m_out_valid && ordy) void'(q.pop_front());
                if (v && m_in_ready) q.push_back({c, d});
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 9'h000, '0, ordy, 1'b0);
    endtask

    logic [PW-1:0] d8;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        stall_m   = 0;
        @(negedge clk);

        // Reset with junk on the inputs; reset must win.
        step(1'b1, 9'h1FF, mk(32'hDEAD), 1'b0, 1'b1);
        step(1'b1, 9'h1FF, mk(32'hBEEF), 1'b0, 1'b0);
        chk("reset_data", out_data, '0);
        rst_n = 1'b1;
        idle(3, 1'b1);

        // Streaming at full rate, pc 0,4,8,C.
        for (int i = 0; i < 4; i++)
            step(1'b1, 9'($urandom), mk(32'(4*i)), 1'b1, 1'b0);
        idle(2, 1'b1);

        // Back-pressure: two accepted, third refused until skid drains.
        step(1'b1, 9'h021, mk(32'h0), 1'b0, 1'b0);
        step(1'b1, 9'h042, mk(32'h4), 1'b0, 1'b0);
        d8 = mk(32'h8);
        step(1'b1, 9'h084, d8, 1'b0, 1'b0);
        chk("hold_pc0", pc_of(out_data), 32'h0);
        chk("hold_in_ready", in_ready, 1'b0);
        step(1'b1, 9'h084, d8, 1'b1, 1'b0);
        chk("pc4_next", pc_of(out_data), 32'h4);
        step(1'b1, 9'h084, d8, 1'b1, 1'b0);
        chk("pc8_next", pc_of(out_data), 32'h8);
        idle(2, 1'b1);

        // Skid full, flush with a valid input in the same cycle.
        step(1'b1, 9'h003, mk(32'h10), 1'b0, 1'b0);
        step(1'b1, 9'h005, mk(32'h14), 1'b0, 1'b0);
        step(1'b1, 9'h10E, mk(32'h100), 1'b1, 1'b1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", out_ctrl, 9'h000);
        chk("flush_ready", in_ready, 1'b1);
        idle(3, 1'b1);

        // rst_n dropping between edges must not disturb outputs until the next edge.
        step(1'b1, 9'h011, mk(32'h20), 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", out_valid, 1'b1);
        chk("async_rst_pc", pc_of(out_data), 32'h20);
        step(1'b1, 9'h011, mk(32'h24), 1'b0, 1'b0);
        chk("midop_rst_data", out_data, '0);
        rst_n = 1'b1;
        idle(2, 1'b1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) rst_n = 1'b0;
            step($urandom_range(0, 9) < 7, 9'($urandom), mk($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            rst_n = 1'b1;
        end
        idle(3, 1'b1);

`ifdef ID_EXE_STALL_CNT_EN
        rst_n = 1'b0;
        step(1'b0, 9'h000, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 9'h001, mk(32'h40), 1'b0, 1'b0);
        idle(10, 1'b0);
        chk("stall_10", stall_cnt, 16'd10);
        step(1'b0, 9'h000, '0, 1'b1, 1'b1);
        chk("stall_after_flush", stall_cnt, 16'd10);
        step(1'b1, 9'h001, mk(32'h44), 1'b0, 1'b0);
        idle(70000, 1'b0);
        chk("stall_sat", stall_cnt, 16'hFFFF);
        idle(2, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
